// File: rtl/mem_responder.sv
// Unified instruction/data memory responder: one request at a time, WAIT_CYCLES wait states,
// one-cycle completion pulse, then holds until strobes drop. Define MEM_PARITY_EN for parity.
module mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Instr_ren,
  input  logic              Mem_ren,
  input  logic              Mem_wen,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] instr_out,
  output logic [DATA_W-1:0] rdata,
  output logic              instr_valid,
  output logic              data_valid,
  output logic              wr_done,
  output logic              busy,
  output logic              req_err,
  output logic              parity_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;
  typedef enum logic [1:0] {R_FETCH, R_READ, R_WRITE} req_t;

`ifdef MEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              state_q, state_d;
  req_t                type_q, type_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   instr_q, rdata_q;
  logic                instr_vld_q, data_vld_q, wr_done_q, req_err_q, req_err_d;
  logic                any_strobe, do_access;
  logic [MW-1:0]       mem [2**ADDR_W];
  logic [MW-1:0]       rd_word, wr_word;

  assign any_strobe = Instr_ren | Mem_ren | Mem_wen;
  assign do_access  = (state_q == S_ACCESS);
  assign rd_word    = mem[addr_q];
`ifdef MEM_PARITY_EN
  assign wr_word    = {^wdata_q, wdata_q};
`else
  assign wr_word    = wdata_q;
`endif

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    req_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Mem_ren && Mem_wen) begin
          req_err_d = 1'b1;
          state_d   = S_HOLD;
        end else if (any_strobe) begin
          // Losing strobes are dropped; the control path re-issues them later.
          if (Mem_wen) begin
            type_d = R_WRITE;
            addr_d = data_addr;
          end else if (Mem_ren) begin
            type_d = R_READ;
            addr_d = data_addr;
          end else begin
            type_d = R_FETCH;
            addr_d = instr_addr;
          end
          wdata_d = wdata;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: state_d = S_HOLD;
      S_HOLD:   if (!any_strobe) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      type_q      <= R_FETCH;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      instr_q     <= '0;
      rdata_q     <= '0;
      instr_vld_q <= 1'b0;
      data_vld_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      req_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_err_q   <= req_err_d;
      instr_vld_q <= do_access && (type_q == R_FETCH);
      data_vld_q  <= do_access && (type_q == R_READ);
      wr_done_q   <= do_access && (type_q == R_WRITE);
      if (do_access && type_q == R_FETCH) instr_q <= rd_word[DATA_W-1:0];
      if (do_access && type_q == R_READ)  rdata_q <= rd_word[DATA_W-1:0];
    end
  end

  // Array is not reset; a reset during ACCESS suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && do_access && type_q == R_WRITE) mem[addr_q] <= wr_word;
  end

`ifdef MEM_PARITY_EN
  logic parity_err_q;
  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= do_access && (type_q != R_WRITE) && (^rd_word);
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign instr_out   = instr_q;
  assign rdata       = rdata_q;
  assign instr_valid = instr_vld_q;
  assign data_valid  = data_vld_q;
  assign wr_done     = wr_done_q;
  assign req_err     = req_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected pulses, a negedge monitor pops/compares.
module tb_mem_responder;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst;
  logic Instr_ren, Mem_ren, Mem_wen;
  logic [7:0]  instr_addr, data_addr;
  logic [15:0] wdata;
  logic [15:0] instr_out, rdata;
  logic instr_valid, data_valid, wr_done, busy, req_err, parity_err;

  // second instance with zero wait states, driven independently
  logic f_iren, f_ren, f_wen;
  logic [7:0]  f_iaddr, f_daddr;
  logic [15:0] f_wd;
  logic [15:0] o0_instr, o0_rdata;
  logic o0_iv, o0_dv, o0_wd, o0_busy, o0_rerr, o0_perr;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .Instr_ren(Instr_ren), .Mem_ren(Mem_ren), .Mem_wen(Mem_wen),
    .instr_addr(instr_addr), .data_addr(data_addr), .wdata(wdata),
    .instr_out(instr_out), .rdata(rdata), .instr_valid(instr_valid), .data_valid(data_valid),
    .wr_done(wr_done), .busy(busy), .req_err(req_err), .parity_err(parity_err));

  mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .Instr_ren(f_iren), .Mem_ren(f_ren), .Mem_wen(f_wen),
    .instr_addr(f_iaddr), .data_addr(f_daddr), .wdata(f_wd),
    .instr_out(o0_instr), .rdata(o0_rdata), .instr_valid(o0_iv), .data_valid(o0_dv),
    .wr_done(o0_wd), .busy(o0_busy), .req_err(o0_rerr), .parity_err(o0_perr));

  // pulses: {parity_err, req_err, wr_done, data_valid, instr_valid}
  typedef struct {
    logic [4:0]  pulses;
    int          cyc;
    logic [15:0] rd;
    logic [15:0] ins;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [256];
  logic [15:0] exp_rd, exp_ins;
  logic        perr_exp;
  int          cyc, n_pass, n_total;
  logic        mon_en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    logic [4:0] obs;
    exp_t e;
    obs = {parity_err, req_err, wr_done, data_valid, instr_valid};
    if (mon_en && obs != 5'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {27'b0, obs}, 32'b0);
      end else begin
        e = sb.pop_front();
        check("pulses", {27'b0, obs}, {27'b0, e.pulses});
        check("pulse_cycle", cyc, e.cyc);
        check("rdata", {16'b0, rdata}, {16'b0, e.rd});
        check("instr_out", {16'b0, instr_out}, {16'b0, e.ins});
      end
    end
  end

  // Called right after a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_req(input logic wen, input logic ren, input logic ien,
                        input logic [7:0] da, input logic [7:0] ia,
                        input logic [15:0] wd, input int hold);
    exp_t e;
    Mem_wen = wen; Mem_ren = ren; Instr_ren = ien;
    data_addr = da; instr_addr = ia; wdata = wd;
    e.pulses = 5'b0;
    e.cyc    = cyc + W + 2;
    if (wen && ren) begin
      e.pulses[3] = 1'b1;
      e.cyc = cyc + 1;
    end else if (wen) begin
      e.pulses[2] = 1'b1;
      model[da] = wd;
    end else if (ren) begin
      e.pulses[1] = 1'b1;
      e.pulses[4] = perr_exp;
      exp_rd = model[da];
    end else begin
      e.pulses[0] = 1'b1;
      e.pulses[4] = perr_exp;
      exp_ins = model[ia];
    end
    e.rd  = exp_rd;
    e.ins = exp_ins;
    sb.push_back(e);
    // address/data changes after acceptance must be ignored
    @(negedge clk);
    data_addr = ~da; instr_addr = ~ia; wdata = ~wd;
    repeat (hold - 1) @(negedge clk);
    Mem_wen = 1'b0; Mem_ren = 1'b0; Instr_ren = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "_ctl"}, {26'b0, busy, instr_valid, data_valid, wr_done, req_err, parity_err}, 32'b0);
    check({nm, "_rdata"}, {16'b0, rdata}, 32'b0);
    check({nm, "_instr"}, {16'b0, instr_out}, 32'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; n_pass = 0; n_total = 0; mon_en = 1'b1;
    exp_rd = '0; exp_ins = '0; perr_exp = 1'b0;
    rst = 1'b1;
    Instr_ren = 0; Mem_ren = 0; Mem_wen = 0; instr_addr = 0; data_addr = 0; wdata = 0;
    f_iren = 0; f_ren = 0; f_wen = 0; f_iaddr = 0; f_daddr = 0; f_wd = 0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);

    // write then read with wait states; busy holds until the strobe drops
    do_req(1, 0, 0, 8'h10, 8'h00, 16'hBEEF, 4);
    do_req(0, 1, 0, 8'h10, 8'h00, 16'h0000, 6);
    Mem_ren = 1'b1; data_addr = 8'h10;
    exp_rd = model[8'h10];
    sb.push_back('{pulses: 5'b00010, cyc: cyc + W + 2, rd: exp_rd, ins: exp_ins});
    repeat (6) @(negedge clk);
    check("busy_while_held", {31'b0, busy}, 32'd1);
    Mem_ren = 1'b0;
    @(negedge clk);
    check("busy_after_drop", {31'b0, busy}, 32'd0);

    // collisions: read beats fetch; read+write is an error with no access
    do_req(1, 0, 0, 8'h05, 8'h00, 16'h5A5A, 4);
    do_req(0, 1, 1, 8'h05, 8'h05, 16'h0000, 4);
    do_req(1, 1, 0, 8'h05, 8'h00, 16'hDEAD, 2);
    do_req(0, 1, 0, 8'h05, 8'h00, 16'h0000, 4);

    // held strobe gives one pulse; a one-cycle gap gives a second
    do_req(0, 1, 0, 8'h10, 8'h00, 16'h0000, 10);
    do_req(0, 1, 0, 8'h05, 8'h00, 16'h0000, 5);

    // fetch leaves rdata alone
    do_req(0, 0, 1, 8'h00, 8'h10, 16'h0000, 4);

    // reset during WAIT aborts the write
    do_req(1, 0, 0, 8'h20, 8'h00, 16'h1111, 4);
    Mem_wen = 1'b1; data_addr = 8'h20; wdata = 16'h2222;
    @(negedge clk);
    check("busy_in_wait", {31'b0, busy}, 32'd1);
    rst = 1'b1; Mem_wen = 1'b0;
    @(negedge clk);
    check_reset_outs("midreset");
    rst = 1'b0; exp_rd = '0; exp_ins = '0;
    @(negedge clk);
    do_req(0, 1, 0, 8'h20, 8'h00, 16'h0000, 4);

    // parity
    do_req(1, 0, 0, 8'h30, 8'h00, 16'h0001, 4);
`ifdef MEM_PARITY_EN
    dut.mem[8'h30][16] = ~dut.mem[8'h30][16];
    perr_exp = 1'b1;
`endif
    do_req(0, 1, 0, 8'h30, 8'h00, 16'h0000, 4);
    perr_exp = 1'b0;

    // zero-wait instance: pulse two cycles after the request is driven
    f_wen = 1'b1; f_daddr = 8'h03; f_wd = 16'h8123;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("w0_wr_done_k%0d", k), {31'b0, o0_wd}, {31'b0, (k == 2)});
    end
    f_wen = 1'b0;
    repeat (2) @(negedge clk);
    f_iren = 1'b1; f_iaddr = 8'h03;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("w0_instr_valid_k%0d", k), {31'b0, o0_iv}, {31'b0, (k == 2)});
    end
    check("w0_instr_out", {16'b0, o0_instr}, 32'h8123);
    check("w0_rdata", {16'b0, o0_rdata}, 32'h0);
    f_iren = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Unified instruction/data memory responder on the slave side of the control-path memory strobes (Instr_ren, Mem_ren, Mem_wen).
- Accepts one request at a time and inserts a programmable number of wait states.
- Performs the array access, then returns a one-cycle completion pulse.
- Blocks re-triggering until the control path drops its strobe, because the control path holds strobes as levels across states.

Parameters:
- DATA_W, 16, word width of instructions and data
- ADDR_W, 8, word address width; depth = 2**ADDR_W
- WAIT_CYCLES, 2, wait states between acceptance and access (0..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- Instr_ren  in  1  instruction fetch strobe (level)
- Mem_ren  in  1  data read strobe (level)
- Mem_wen  in  1  data write strobe (level)
- instr_addr  in  ADDR_W  fetch word address (PC)
- data_addr  in  ADDR_W  data word address (ALU result)
- wdata  in  DATA_W  store data
- instr_out  out  DATA_W  fetched instruction, held until next fetch completes
- rdata  out  DATA_W  read data, held until next data read completes
- instr_valid  out  1  one-cycle pulse: instr_out updated
- data_valid  out  1  one-cycle pulse: rdata updated
- wr_done  out  1  one-cycle pulse: write committed
- busy  out  1  high in every state except IDLE
- req_err  out  1  one-cycle pulse: illegal request
- parity_err  out  1  one-cycle pulse on a read parity mismatch (MEM_PARITY_EN only)

Behaviour:
- Reset (rst=1 at a clk edge) has priority over all else:
  - FSM goes to IDLE.
  - All outputs, including instr_out and rdata, go to 0.
  - Latched request and wait counter clear.
  - Array contents are not reset.
  - Reset mid-request aborts it: no write commits and no valid pulse is issued.
- States and transitions:
  - IDLE: samples the strobes.
    - Mem_ren & Mem_wen both high: pulse req_err the next cycle, go to HOLD, no access.
    - Otherwise any strobe high: latch the request, then go to WAIT if WAIT_CYCLES>0, else to ACCESS.
    - Priority: Mem_wen > Mem_ren > Instr_ren. The losing strobe is dropped, not queued.
    - Latched fields: type, the selected address, wdata.
  - WAIT: counter loads WAIT_CYCLES-1 on entry and decrements each cycle. Go to ACCESS when the count reaches 0.
  - ACCESS: exactly one cycle.
    - Write: mem[addr] <= wdata, wr_done=1.
    - Data read: rdata <= mem[addr], data_valid=1.
    - Fetch: instr_out <= mem[addr], instr_valid=1.
    - The pulse is registered, asserted in the cycle after ACCESS, together with the updated output register.
    - Go to HOLD.
  - HOLD: stay while any strobe is high; go to IDLE on the first cycle with all strobes low.
- Latency:
  - Strobe sampled in IDLE at edge N; completion pulse high in cycle N+WAIT_CYCLES+2.
  - WAIT_CYCLES=0 gives N+2.
- Request inputs:
  - Inputs are sampled only at acceptance; changes to address or data during WAIT, ACCESS or HOLD are ignored.
  - Strobes arriving while busy are ignored silently; no req_err.
- Addressing: address width equals ADDR_W, so there is no wrap-around and no out-of-range condition.
- Pulse rules:
  - The three completion pulses are mutually exclusive.
  - Every pulse is high for exactly one cycle.
- Read-after-write: a read to an address written by the previous request returns the new data.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - The array stores DATA_W+1 bits per word; the extra bit is even parity of the data, computed on write.
  - On a read or fetch, a mismatch pulses parity_err in the same cycle as the valid pulse. The data is still returned.
- Undefined:
  - The array is DATA_W bits wide.
  - parity_err is tied to 0.
- The port list is identical in both builds.

Test Plan:
- Write then read, WAIT_CYCLES=2: Mem_wen=1, data_addr=0x10, wdata=0xBEEF, held 4 cycles then dropped -> wr_done pulses 4 cycles after acceptance. Then Mem_ren at 0x10 -> data_valid pulses at acceptance+4, rdata=0xBEEF, busy falls only after Mem_ren drops.
- Fetch with WAIT_CYCLES=0: preload mem[0x03]=0x8123, Instr_ren=1, instr_addr=0x03 -> instr_valid at acceptance+2, instr_out=0x8123, rdata unchanged.
- Collision: Instr_ren=1 and Mem_ren=1 together at address 0x05 -> only data_valid pulses, with rdata=mem[0x05]. Mem_ren=1 and Mem_wen=1 -> req_err pulse, no array change, no valid pulse.
- Held strobe: Mem_ren held 10 cycles -> exactly one data_valid pulse. Toggle Mem_ren low 1 cycle then high -> second pulse.
- Reset mid-write: assert rst during WAIT of a write to 0x20 (old value 0x1111) -> all outputs 0 next cycle. A later read of 0x20 returns 0x1111.
- Parity (MEM_PARITY_EN): write 0x0001, force-flip the stored parity bit via hierarchical access, then read -> data_valid and parity_err pulse in the same cycle, rdata=0x0001. Without the macro -> parity_err stays 0.
